// File: rtl/clk_div_multi_pkg.sv
// Shared types and elaboration helpers for the multi-channel clock divider.
package clk_div_multi_pkg;

    typedef enum logic [0:0] {
        PARK = 1'b0,
        RUN  = 1'b1
    } ch_state_t;

    // Channel-select width; a single channel still gets a 1-bit select.
    function automatic int unsigned ch_w(input int unsigned n);
        return (n <= 32'd2) ? 32'd1 : unsigned'($clog2(n));
    endfunction

    function automatic int unsigned div_rst(input int unsigned freq_clk,
                                            input int unsigned freq_out);
        return freq_clk / freq_out / 32'd2;
    endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: shadow/active half-period, down-counter, PARK/RUN state
// and registered clock, rise and fall strobes.
module clk_div_ch
    import clk_div_multi_pkg::*;
#(
    parameter int unsigned DIV_W   = 16,
    parameter int unsigned DIV_RST = 4
) (
    input  logic             clk_in,
    input  logic             aclr_n,
    input  logic             wr_i,
    input  logic [DIV_W-1:0] wr_div_i,
    input  logic             en_i,
    input  logic             sync_i,
    output logic             clk_out_o,
    output logic             rise_tick_o,
    output logic             fall_tick_o
);

    typedef logic [DIV_W-1:0] div_t;

    localparam div_t DivRst = div_t'(DIV_RST);
    localparam div_t DivOne = div_t'(1);

    ch_state_t state_q;
    div_t      cnt_q;
    div_t      shadow_q;
    div_t      active_q;
    logic      out_q;
    logic      rise_q;
    logic      fall_q;

    always_ff @(posedge clk_in or negedge aclr_n) begin
        if (!aclr_n) begin
            state_q  <= PARK;
            cnt_q    <= '0;
            shadow_q <= DivRst;
            active_q <= DivRst;
            out_q    <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            // Shadow is only read from its register, so a write never bypasses
            // into a boundary happening on the same edge.
            if (wr_i) begin
                shadow_q <= (wr_div_i == '0) ? DivOne : wr_div_i;
            end
            if (sync_i) begin
                state_q <= PARK;
                out_q   <= 1'b0;
                cnt_q   <= '0;
            end else begin
                unique case (state_q)
                    PARK: begin
                        out_q <= 1'b0;
                        cnt_q <= '0;
                        if (en_i) begin
                            state_q  <= RUN;
                            active_q <= shadow_q;
                            cnt_q    <= shadow_q - DivOne;
                            out_q    <= 1'b1;
                            rise_q   <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - DivOne;
                        end else if (out_q) begin
                            out_q  <= 1'b0;
                            fall_q <= 1'b1;
                            if (!en_i) begin
                                state_q <= PARK;
                                cnt_q   <= '0;
                            end else begin
                                cnt_q <= active_q - DivOne;
                            end
                        end else if (!en_i) begin
                            state_q <= PARK;
                        end else begin
                            active_q <= shadow_q;
                            cnt_q    <= shadow_q - DivOne;
                            out_q    <= 1'b1;
                            rise_q   <= 1'b1;
                        end
                    end
                    default: state_q <= PARK;
                endcase
            end
        end
    end

    assign clk_out_o   = out_q;
    assign rise_tick_o = rise_q;
    assign fall_tick_o = fall_q;

endmodule

// File: rtl/clk_div_multi.sv
// N_CH independent 50%-duty dividers with runtime half-period writes,
// per-channel enable and a global phase restart.
module clk_div_multi
    import clk_div_multi_pkg::*;
#(
    parameter  int unsigned FREQ_CLK = 2_000_000,
    parameter  int unsigned FREQ_OUT = 250_000,
    parameter  int unsigned N_CH     = 4,
    parameter  int unsigned DIV_W    = 16,
    localparam int unsigned CH_W     = ch_w(N_CH)
) (
    input  logic             clk_in,
    input  logic             aclr_n,
    input  logic             wr_en,
    input  logic [CH_W-1:0]  wr_ch,
    input  logic [DIV_W-1:0] wr_div,
    input  logic [N_CH-1:0]  ch_en,
    input  logic             sync,
    output logic [N_CH-1:0]  clk_out,
    output logic [N_CH-1:0]  rise_tick,
    output logic [N_CH-1:0]  fall_tick
);

    localparam int unsigned DIV_RST = div_rst(FREQ_CLK, FREQ_OUT);

    logic [N_CH-1:0] wr_sel;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        // Out-of-range selects match no channel and are dropped.
        assign wr_sel[i] = wr_en && (int'(wr_ch) == i);

        clk_div_ch #(
            .DIV_W   (DIV_W),
            .DIV_RST (DIV_RST)
        ) u_ch (
            .clk_in      (clk_in),
            .aclr_n      (aclr_n),
            .wr_i        (wr_sel[i]),
            .wr_div_i    (wr_div),
            .en_i        (ch_en[i]),
            .sync_i      (sync),
            .clk_out_o   (clk_out[i]),
            .rise_tick_o (rise_tick[i]),
            .fall_tick_o (fall_tick[i])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: a 4-channel instance plus a 3-channel one
// so that an out-of-range channel select is representable.
module tb_clk_div_multi;

    logic        clk_in;
    logic        aclr_n;
    logic        wr_en;
    logic [1:0]  wr_ch;
    logic [15:0] wr_div;
    logic [3:0]  ch_en;
    logic        sync;
    logic [3:0]  clk_out;
    logic [3:0]  rise_tick;
    logic [3:0]  fall_tick;

    logic        wr_en3;
    logic [1:0]  wr_ch3;
    logic [15:0] wr_div3;
    logic [2:0]  en3;
    logic [2:0]  clk_out3;
    logic [2:0]  rise3;
    logic [2:0]  fall3;

    int n_cmp;
    int n_err;

    clk_div_multi dut (
        .clk_in    (clk_in),
        .aclr_n    (aclr_n),
        .wr_en     (wr_en),
        .wr_ch     (wr_ch),
        .wr_div    (wr_div),
        .ch_en     (ch_en),
        .sync      (sync),
        .clk_out   (clk_out),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    clk_div_multi #(.N_CH(3)) dut3 (
        .clk_in    (clk_in),
        .aclr_n    (aclr_n),
        .wr_en     (wr_en3),
        .wr_ch     (wr_ch3),
        .wr_div    (wr_div3),
        .ch_en     (en3),
        .sync      (sync),
        .clk_out   (clk_out3),
        .rise_tick (rise3),
        .fall_tick (fall3)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Holds reset across two edges and releases just after a rising edge.
    task automatic reset_dut(input logic [3:0] en, input logic [2:0] e3);
        aclr_n = 1'b0;
        ch_en  = en;
        en3    = e3;
        wr_en  = 1'b0;
        wr_en3 = 1'b0;
        sync   = 1'b0;
        step();
        step();
        aclr_n = 1'b1;
    endtask

    task automatic test_reset();
        aclr_n = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_div = '0; ch_en = '0; sync = 1'b0;
        wr_en3 = 1'b0; wr_ch3 = '0; wr_div3 = '0; en3 = '0;
        #1 aclr_n = 1'b0;
        #2;
        n_cmp++;
        if (clk_out !== 4'b0) begin n_err++; $display("FAIL reset clk_out got %b want 0000", clk_out); end
        n_cmp++;
        if (rise_tick !== 4'b0) begin n_err++; $display("FAIL reset rise_tick got %b want 0000", rise_tick); end
        n_cmp++;
        if (fall_tick !== 4'b0) begin n_err++; $display("FAIL reset fall_tick got %b want 0000", fall_tick); end
        n_cmp++;
        if (clk_out3 !== 3'b0) begin n_err++; $display("FAIL reset3 clk_out got %b want 000", clk_out3); end
    endtask

    task automatic test_basic();
        logic [3:0] eo, er, ef;
        reset_dut(4'b0001, 3'b000);
        for (int k = 1; k <= 24; k++) begin
            step();
            eo = {3'b0, ((k - 1) % 8) < 4};
            er = {3'b0, ((k - 1) % 8) == 0};
            ef = {3'b0, ((k - 1) % 8) == 4};
            n_cmp++;
            if (clk_out !== eo) begin n_err++; $display("FAIL basic k=%0d clk_out got %b want %b", k, clk_out, eo); end
            n_cmp++;
            if (rise_tick !== er) begin n_err++; $display("FAIL basic k=%0d rise got %b want %b", k, rise_tick, er); end
            n_cmp++;
            if (fall_tick !== ef) begin n_err++; $display("FAIL basic k=%0d fall got %b want %b", k, fall_tick, ef); end
        end
    endtask

    task automatic test_div_change();
        logic [3:0] eo, er, ef;
        logic hi, r, f;
        reset_dut(4'b0010, 3'b000);
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k <= 8) begin
                hi = ((k - 1) % 8) < 4; r = (k == 1); f = (k == 5);
            end else begin
                hi = ((k - 9) % 4) < 2; r = ((k - 9) % 4) == 0; f = ((k - 9) % 4) == 2;
            end
            eo = {2'b0, hi, 1'b0};
            er = {2'b0, r, 1'b0};
            ef = {2'b0, f, 1'b0};
            n_cmp++;
            if (clk_out !== eo) begin n_err++; $display("FAIL div_change k=%0d clk_out got %b want %b", k, clk_out, eo); end
            n_cmp++;
            if (rise_tick !== er) begin n_err++; $display("FAIL div_change k=%0d rise got %b want %b", k, rise_tick, er); end
            n_cmp++;
            if (fall_tick !== ef) begin n_err++; $display("FAIL div_change k=%0d fall got %b want %b", k, fall_tick, ef); end
            if (k == 2) begin wr_en = 1'b1; wr_ch = 2'd1; wr_div = 16'd2; end
            if (k == 3) wr_en = 1'b0;
        end
    endtask

    task automatic test_disable();
        logic [3:0] eo, er, ef;
        reset_dut(4'b0100, 3'b000);
        for (int k = 1; k <= 22; k++) begin
            step();
            eo = {1'b0, (k <= 4) || (k >= 11 && k <= 14), 2'b0};
            er = {1'b0, (k == 1) || (k == 11), 2'b0};
            ef = {1'b0, (k == 5) || (k == 15), 2'b0};
            n_cmp++;
            if (clk_out !== eo) begin n_err++; $display("FAIL disable k=%0d clk_out got %b want %b", k, clk_out, eo); end
            n_cmp++;
            if (rise_tick !== er) begin n_err++; $display("FAIL disable k=%0d rise got %b want %b", k, rise_tick, er); end
            n_cmp++;
            if (fall_tick !== ef) begin n_err++; $display("FAIL disable k=%0d fall got %b want %b", k, fall_tick, ef); end
            if (k == 1) ch_en = 4'b0000;
            if (k == 10) ch_en = 4'b0100;
            if (k == 16) ch_en = 4'b0000;
        end
    endtask

    task automatic test_sync();
        logic [3:0] eo, er, ef;
        reset_dut(4'b0000, 3'b000);
        step();
        wr_en = 1'b1; wr_ch = 2'd0; wr_div = 16'd6;
        step();
        wr_ch = 2'd1; wr_div = 16'd5;
        step();
        wr_en = 1'b0; ch_en = 4'b0001;
        step();
        step();
        ch_en = 4'b0011;
        step();
        step();
        step();
        // Both channels are high here; the coincident write must reach the restart.
        sync = 1'b1; wr_en = 1'b1; wr_ch = 2'd0; wr_div = 16'd3;
        step();
        sync = 1'b0; wr_en = 1'b0;
        n_cmp++;
        if (clk_out !== 4'b0) begin n_err++; $display("FAIL sync_park clk_out got %b want 0000", clk_out); end
        n_cmp++;
        if (rise_tick !== 4'b0) begin n_err++; $display("FAIL sync_park rise got %b want 0000", rise_tick); end
        n_cmp++;
        if (fall_tick !== 4'b0) begin n_err++; $display("FAIL sync_park fall got %b want 0000", fall_tick); end
        for (int j = 0; j < 30; j++) begin
            step();
            eo = {2'b0, (j % 10) < 5, (j % 6) < 3};
            er = {2'b0, (j % 10) == 0, (j % 6) == 0};
            ef = {2'b0, (j % 10) == 5, (j % 6) == 3};
            n_cmp++;
            if (clk_out !== eo) begin n_err++; $display("FAIL sync j=%0d clk_out got %b want %b", j, clk_out, eo); end
            n_cmp++;
            if (rise_tick !== er) begin n_err++; $display("FAIL sync j=%0d rise got %b want %b", j, rise_tick, er); end
            n_cmp++;
            if (fall_tick !== ef) begin n_err++; $display("FAIL sync j=%0d fall got %b want %b", j, fall_tick, ef); end
        end
    endtask

    task automatic test_div_zero();
        logic [3:0] eo, er, ef;
        logic hi, r, f;
        reset_dut(4'b1000, 3'b111);
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k <= 8) begin
                hi = ((k - 1) % 8) < 4; r = (k == 1); f = (k == 5);
            end else begin
                hi = ((k - 9) % 2) == 0; r = hi; f = !hi;
            end
            eo = {hi, 3'b0};
            er = {r, 3'b0};
            ef = {f, 3'b0};
            n_cmp++;
            if (clk_out !== eo) begin n_err++; $display("FAIL div_zero k=%0d clk_out got %b want %b", k, clk_out, eo); end
            n_cmp++;
            if (rise_tick !== er) begin n_err++; $display("FAIL div_zero k=%0d rise got %b want %b", k, rise_tick, er); end
            n_cmp++;
            if (fall_tick !== ef) begin n_err++; $display("FAIL div_zero k=%0d fall got %b want %b", k, fall_tick, ef); end
            // Out-of-range channel on the 3-channel instance must change nothing.
            n_cmp++;
            if (clk_out3 !== {3{((k - 1) % 8) < 4}}) begin
                n_err++; $display("FAIL bad_ch k=%0d clk_out got %b want %b", k, clk_out3, {3{((k - 1) % 8) < 4}});
            end
            n_cmp++;
            if (rise3 !== {3{((k - 1) % 8) == 0}}) begin
                n_err++; $display("FAIL bad_ch k=%0d rise got %b want %b", k, rise3, {3{((k - 1) % 8) == 0}});
            end
            if (k == 1) begin
                wr_en = 1'b1; wr_ch = 2'd3; wr_div = 16'd0;
                wr_en3 = 1'b1; wr_ch3 = 2'd3; wr_div3 = 16'd1;
            end
            if (k == 2) begin wr_en = 1'b0; wr_en3 = 1'b0; end
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] eo, er, ef;
        reset_dut(4'b1111, 3'b000);
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 1) begin wr_en = 1'b1; wr_ch = 2'd1; wr_div = 16'd2; end
            if (k == 2) begin wr_ch = 2'd2; wr_div = 16'd7; end
            if (k == 3) wr_en = 1'b0;
        end
        // Channel 0 is in its second high cycle; drop reset between edges.
        #3 aclr_n = 1'b0;
        #1;
        n_cmp++;
        if (clk_out !== 4'b0) begin n_err++; $display("FAIL async clk_out got %b want 0000", clk_out); end
        n_cmp++;
        if (rise_tick !== 4'b0) begin n_err++; $display("FAIL async rise got %b want 0000", rise_tick); end
        n_cmp++;
        if (fall_tick !== 4'b0) begin n_err++; $display("FAIL async fall got %b want 0000", fall_tick); end
        step();
        n_cmp++;
        if (clk_out !== 4'b0) begin n_err++; $display("FAIL async_hold clk_out got %b want 0000", clk_out); end
        aclr_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            eo = {4{((k - 1) % 8) < 4}};
            er = {4{((k - 1) % 8) == 0}};
            ef = {4{((k - 1) % 8) == 4}};
            n_cmp++;
            if (clk_out !== eo) begin n_err++; $display("FAIL post_reset k=%0d clk_out got %b want %b", k, clk_out, eo); end
            n_cmp++;
            if (rise_tick !== er) begin n_err++; $display("FAIL post_reset k=%0d rise got %b want %b", k, rise_tick, er); end
            n_cmp++;
            if (fall_tick !== ef) begin n_err++; $display("FAIL post_reset k=%0d fall got %b want %b", k, fall_tick, ef); end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_div_change();
        test_disable();
        test_sync();
        test_div_zero();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
